// File: rtl/axis_bram_capture.sv
// Triggered AXI4-Stream to BRAM capture engine.
// Packs samples into BRAM words, runs a ring buffer and stops after a post-trigger count.
module axis_bram_capture #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [BRAM_ADDR_WIDTH:0]       cfg_length,
    input  logic [BRAM_ADDR_WIDTH:0]       cfg_post,
    input  logic                           start,
    input  logic                           trigger,
    output logic [BRAM_ADDR_WIDTH-1:0]     sts_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]     sts_trg_addr,
    output logic                           sts_wrapped,
    output logic                           sts_done,
    input  logic [AXIS_TDATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic                           b_bram_clk,
    output logic                           b_bram_rst,
    output logic                           b_bram_en,
    output logic [BRAM_DATA_WIDTH/8-1:0]   b_bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]     b_bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0]     b_bram_wdata
);

    localparam int R  = BRAM_DATA_WIDTH / AXIS_TDATA_WIDTH;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int LW = BRAM_ADDR_WIDTH + 1;
    localparam int AW = BRAM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, POST, DONE} state_t;

    state_t                     state_q;
    logic [LW-1:0]              len_q;
    logic [LW-1:0]              post_q;
    logic [AW-1:0]              addr_q;
    logic [AW-1:0]              trg_addr_q;
    logic                       wrapped_q;
    logic                       done_q;
    logic [CW-1:0]              cnt_q;
    logic [BRAM_DATA_WIDTH-1:0] pack_q;
    logic                       en_q;
    logic [BRAM_DATA_WIDTH/8-1:0] we_q;
    logic [AW-1:0]              baddr_q;
    logic [BRAM_DATA_WIDTH-1:0] wdata_q;

    logic [BRAM_DATA_WIDTH-1:0] word_d;
    logic [AW-1:0]              addr_d;
    logic                       wrap_hit;
    logic                       complete;
    logic                       accept;
    logic                       kill;
    logic                       wr;

    always_comb begin
        word_d = pack_q;
        for (int k = 0; k < R; k++) begin
            if (cnt_q == CW'(k))
                word_d[k*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH] = s_axis_tdata;
        end
    end

    assign complete = (cnt_q == CW'(R - 1));
    assign accept   = s_axis_tvalid && (state_q == RUN || state_q == POST);
    // A zero post count drops the trigger-cycle sample and any partial word.
    assign kill     = (state_q == RUN && trigger && cfg_post == '0) ||
                      (state_q == POST && post_q == '0);
    assign wr       = accept && !kill && complete;
    assign wrap_hit = ({1'b0, addr_q} == len_q - LW'(1));
    assign addr_d   = wrap_hit ? '0 : addr_q + AW'(1);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            post_q     <= '0;
            addr_q     <= '0;
            trg_addr_q <= '0;
            wrapped_q  <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            pack_q     <= '0;
            en_q       <= 1'b0;
            we_q       <= '0;
            baddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            en_q <= 1'b0;
            we_q <= '0;

            if (accept && !kill) begin
                if (complete) begin
                    en_q    <= 1'b1;
                    we_q    <= '1;
                    baddr_q <= addr_q;
                    wdata_q <= word_d;
                    addr_q  <= addr_d;
                    cnt_q   <= '0;
                    pack_q  <= '0;
                    if (wrap_hit)
                        wrapped_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_q + CW'(1);
                    pack_q <= word_d;
                end
            end
            if (kill) begin
                cnt_q  <= '0;
                pack_q <= '0;
            end

            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        len_q      <= cfg_length;
                        addr_q     <= '0;
                        cnt_q      <= '0;
                        pack_q     <= '0;
                        wrapped_q  <= 1'b0;
                        done_q     <= 1'b0;
                        trg_addr_q <= '0;
                        if (trigger) begin
                            post_q  <= cfg_post;
                            state_q <= POST;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (trigger) begin
                        trg_addr_q <= addr_q;
                        if (cfg_post == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (wr) begin
                            // Trigger-cycle sample completed a word: it is the first post write.
                            post_q <= cfg_post - LW'(1);
                            if (cfg_post == LW'(1)) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= POST;
                            end
                        end else begin
                            post_q  <= cfg_post;
                            state_q <= POST;
                        end
                    end
                end
                POST: begin
                    if (post_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (wr) begin
                        post_q <= post_q - LW'(1);
                        if (post_q == LW'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sts_addr      = addr_q;
    assign sts_trg_addr  = trg_addr_q;
    assign sts_wrapped   = wrapped_q;
    assign sts_done      = done_q;
    assign s_axis_tready = 1'b1;
    assign b_bram_clk    = aclk;
    assign b_bram_rst    = ~aresetn;
    assign b_bram_en     = en_q;
    assign b_bram_we     = we_q;
    assign b_bram_addr   = baddr_q;
    assign b_bram_wdata  = wdata_q;

endmodule

// File: tb/tb_axis_bram_capture.sv
// Scoreboard bench for axis_bram_capture: a queue-based model predicts BRAM writes
// and status, a negedge monitor checks every write it sees.
module tb_axis_bram_capture;

    localparam int W  = 16;
    localparam int BW = 32;
    localparam int AW = 4;
    localparam int R  = BW / W;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [AW:0]     cfg_length = 5'd16;
    logic [AW:0]     cfg_post = 5'd0;
    logic            start = 1'b0;
    logic            trigger = 1'b0;
    logic [AW-1:0]   sts_addr;
    logic [AW-1:0]   sts_trg_addr;
    logic            sts_wrapped;
    logic            sts_done;
    logic [W-1:0]    s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic            b_bram_clk;
    logic            b_bram_rst;
    logic            b_bram_en;
    logic [BW/8-1:0] b_bram_we;
    logic [AW-1:0]   b_bram_addr;
    logic [BW-1:0]   b_bram_wdata;

    axis_bram_capture #(
        .AXIS_TDATA_WIDTH(W),
        .BRAM_DATA_WIDTH(BW),
        .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_length(cfg_length), .cfg_post(cfg_post),
        .start(start), .trigger(trigger),
        .sts_addr(sts_addr), .sts_trg_addr(sts_trg_addr),
        .sts_wrapped(sts_wrapped), .sts_done(sts_done),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .b_bram_clk(b_bram_clk), .b_bram_rst(b_bram_rst),
        .b_bram_en(b_bram_en), .b_bram_we(b_bram_we),
        .b_bram_addr(b_bram_addr), .b_bram_wdata(b_bram_wdata)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        int            c;
    } exp_t;
    exp_t q[$];

    // Reference model: mode 0 idle, 1 armed, 2 post, 3 done.
    int          m_mode = 0;
    int          m_len = 1;
    int          m_addr = 0;
    int          m_post = 0;
    int          m_trg = 0;
    bit          m_wrap = 0;
    bit          m_done = 0;
    logic [W-1:0] part[$];

    task automatic model_reset();
        m_mode = 0; m_len = 1; m_addr = 0; m_post = 0;
        m_trg = 0; m_wrap = 0; m_done = 0;
        part.delete();
    endtask

    task automatic model_take(logic [W-1:0] d);
        logic [BW-1:0] w;
        exp_t e;
        part.push_back(d);
        if (part.size() == R) begin
            w = '0;
            for (int k = 0; k < R; k++) w[k*W +: W] = part[k];
            e.a = m_addr[AW-1:0];
            e.d = w;
            e.c = cyc + 1;
            q.push_back(e);
            part.delete();
            m_addr = (m_addr + 1) % m_len;
            if (m_addr == 0) m_wrap = 1;
            if (m_mode == 2) begin
                m_post--;
                if (m_post == 0) begin m_mode = 3; m_done = 1; end
            end
        end
    endtask

    task automatic model_step(bit st, bit tr, bit v, logic [W-1:0] d,
                              int clen, int cpost);
        bit take;
        if (!aresetn) begin model_reset(); return; end
        case (m_mode)
            0, 3: if (st) begin
                m_len = clen; m_addr = 0; m_wrap = 0; m_done = 0; m_trg = 0;
                part.delete();
                if (tr) begin m_mode = 2; m_post = cpost; end
                else m_mode = 1;
            end
            1: begin
                take = v;
                if (tr) begin
                    m_trg = m_addr;
                    if (cpost == 0) begin
                        m_mode = 3; m_done = 1; part.delete(); take = 0;
                    end else begin
                        m_mode = 2; m_post = cpost;
                    end
                end
                if (take) model_take(d);
            end
            2: begin
                if (m_post == 0) begin
                    m_mode = 3; m_done = 1; part.delete();
                end else if (v) model_take(d);
            end
            default: ;
        endcase
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (b_bram_en) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%08h", b_bram_addr, b_bram_wdata);
            end else begin
                e = q.pop_front();
                if (b_bram_addr !== e.a || b_bram_wdata !== e.d ||
                    b_bram_we !== 4'hF || cyc != e.c) begin
                    errors++;
                    $display("FAIL bram_write got addr=%0h data=%08h we=%h cyc=%0d exp addr=%0h data=%08h we=f cyc=%0d",
                             b_bram_addr, b_bram_wdata, b_bram_we, cyc, e.a, e.d, e.c);
                end
            end
        end else if (q.size() > 0 && q[0].c <= cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing_write exp addr=%0h data=%08h cyc=%0d now=%0d", e.a, e.d, e.c, cyc);
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_status();
        chk("sts_addr", 32'(sts_addr), 32'(m_addr));
        chk("sts_trg_addr", 32'(sts_trg_addr), 32'(m_trg));
        chk("sts_wrapped", 32'(sts_wrapped), 32'(m_wrap));
        chk("sts_done", 32'(sts_done), 32'(m_done));
        chk("tready", 32'(s_axis_tready), 32'd1);
    endtask

    task automatic tick(bit st, bit tr, bit v, logic [W-1:0] d);
        start = st; trigger = tr; s_axis_tvalid = v; s_axis_tdata = d;
        model_step(st, tr, v, d, int'(cfg_length), int'(cfg_post));
        @(posedge aclk);
        #1;
        start = 1'b0; trigger = 1'b0; s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick(0, 0, 0, '0);
        chk("bram_rst", 32'(b_bram_rst), 32'd1);
        tick(0, 0, 1, 16'hBEEF);
        aresetn = 1'b1;
        chk("rst_en", 32'(b_bram_en), 32'd0);
        chk("rst_we", 32'(b_bram_we), 32'd0);
        chk("rst_addr", 32'(b_bram_addr), 32'd0);
        chk("rst_wdata", b_bram_wdata, 32'd0);
        check_status();
    endtask

    initial begin
        logic [W-1:0] s;
        // Reset and idle: samples ignored, nothing written
        do_reset();
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 16'(i + 100));
        check_status();

        // One-shot: start+trigger, four post words
        cfg_length = 5'd16; cfg_post = 5'd4;
        tick(1, 1, 0, '0);
        for (int i = 1; i <= 8; i++) tick(0, 0, 1, 16'(i));
        chk("oneshot_done", 32'(sts_done), 32'd1);
        chk("oneshot_addr", 32'(sts_addr), 32'd4);
        chk("oneshot_trg", 32'(sts_trg_addr), 32'd0);
        check_status();

        // Ring wrap with length 3, trigger on sample 11
        cfg_length = 5'd3; cfg_post = 5'd2;
        tick(1, 0, 0, '0);
        for (int i = 1; i <= 10; i++) tick(0, 0, 1, 16'(i));
        chk("ring_wrapped", 32'(sts_wrapped), 32'd1);
        tick(0, 1, 1, 16'd11);
        for (int i = 12; i <= 14; i++) tick(0, 0, 1, 16'(i));
        chk("ring_trg", 32'(sts_trg_addr), 32'd2);
        chk("ring_addr", 32'(sts_addr), 32'd1);
        chk("ring_done", 32'(sts_done), 32'd1);
        check_status();

        // Zero post: trigger on first sample of a word
        cfg_length = 5'd16; cfg_post = 5'd0;
        tick(1, 0, 0, '0);
        for (int i = 1; i <= 4; i++) tick(0, 0, 1, 16'(i + 16'h40));
        tick(0, 1, 1, 16'h0055);
        chk("zero_done", 32'(sts_done), 32'd1);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 16'h0066);
        check_status();

        // tvalid gaps
        cfg_length = 5'd16; cfg_post = 5'd16;
        tick(1, 0, 0, '0);
        for (int i = 0; i < 16; i++) tick(0, 0, i[0], 16'(16'h0a00 + i));
        check_status();

        // Reset mid-POST, then restart
        cfg_length = 5'd8; cfg_post = 5'd3;
        tick(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 16'(16'h0b00 + i));
        tick(0, 1, 1, 16'h0c00);
        tick(0, 0, 1, 16'h0c01);
        do_reset();
        tick(1, 0, 0, '0);
        tick(0, 0, 1, 16'h0d00);
        tick(0, 0, 1, 16'h0d01);
        chk("restart_addr", 32'(sts_addr), 32'd1);
        chk("restart_wrapped", 32'(sts_wrapped), 32'd0);
        check_status();

        // Randomized traffic with occasional resets
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < 150; c++) begin
                cfg_length = 5'($urandom_range(1, 16));
                cfg_post = 5'($urandom_range(0, 16));
                s = 16'($urandom);
                if ($urandom_range(0, 199) == 0) aresetn = 1'b0;
                tick($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
                     $urandom_range(0, 3) != 0, s);
                aresetn = 1'b1;
                check_status();
            end
        end

        tick(0, 0, 0, '0);
        tick(0, 0, 0, '0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
